// File: rtl/servisia_pkg.sv
// Shared definitions for the UART boot loader: FSM encodings and UART framing constants.
package servisia_pkg;

    localparam int UART_BITS = 8;

    typedef enum logic [2:0] {
        BOOT_HDR_LO,
        BOOT_HDR_HI,
        BOOT_DATA,
        BOOT_CSUM,
        BOOT_RUN
    } boot_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_BITS,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid or framing-error pulse.
module uart_rx
    import servisia_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [UART_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(UART_BITS);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(UART_BITS - 1);

    logic                 rx_meta, rx_sync, rx_prev;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [UART_BITS-1:0] shift_q, shift_d;
    logic                 valid_d, frame_err_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            rx_prev     <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_sync     <= rx_meta;
            rx_prev     <= rx_sync;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            valid_o     <= valid_d;
            frame_err_o <= frame_err_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A start bit that is high again at mid-bit was only a glitch.
                    state_d = rx_sync ? RX_IDLE : RX_BITS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_BITS: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[UART_BITS-1:1]};
                    bit_d   = bit_q + BW'(1);
                    if (bit_q == LAST_BIT) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d       = '0;
                    state_d     = RX_IDLE;
                    valid_d     = rx_sync;
                    frame_err_d = !rx_sync;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o = shift_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives a length/payload/checksum frame over UART into SRAM, then hands
// the SRAM port to the core as a combinational pass-through.
module uart_boot_loader
    import servisia_pkg::*;
#(
    parameter int aw           = 14,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          uart_rx_i,
    output logic          core_rst_o,
    input  logic [aw-1:0] core_waddr_i,
    input  logic [7:0]    core_wdata_i,
    input  logic          core_wen_i,
    input  logic [aw-1:0] core_raddr_i,
    input  logic          core_ren_i,
    output logic [7:0]    core_rdata_o,
    output logic [aw-1:0] sram_addr_o,
    output logic [7:0]    sram_wdata_o,
    output logic          sram_wen_o,
    output logic          sram_ren_o,
    input  logic [7:0]    sram_rdata_i,
    output logic          done_o,
    output logic          err_o
);
    localparam logic [16:0] MEMSIZE = 17'(1 << aw);

    logic [UART_BITS-1:0] rx_data;
    logic                 rx_valid, rx_frame_err;
    boot_state_t          state_q, state_d;
    logic [aw:0]          addr_q, addr_d, addr_inc, len_q, len_d;
    logic [7:0]           len_lo_q, len_lo_d, sum_q, sum_d, wdata_q, wdata_d;
    logic [aw-1:0]        waddr_q, waddr_d;
    logic                 wen_q, wen_d, err_q, err_d;
    logic [16:0]          frame_len;
    logic                 run;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (uart_rx_i),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_frame_err)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= BOOT_HDR_LO;
            addr_q   <= '0;
            len_q    <= '0;
            len_lo_q <= '0;
            sum_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            len_lo_q <= len_lo_d;
            sum_q    <= sum_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            err_q    <= err_d;
        end
    end

    // The counter carries one extra bit so a full-memory image ends without wrapping to 0.
    assign addr_inc  = addr_q + (aw + 1)'(1);
    assign frame_len = {1'b0, rx_data, len_lo_q};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        len_lo_d = len_lo_q;
        sum_d    = sum_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b0;
        err_d    = err_q;
        if (state_q != BOOT_RUN && rx_frame_err) begin
            state_d = BOOT_HDR_LO;
            err_d   = 1'b1;
            addr_d  = '0;
            sum_d   = '0;
        end else if (state_q != BOOT_RUN && rx_valid) begin
            case (state_q)
                BOOT_HDR_LO: begin
                    len_lo_d = rx_data;
                    state_d  = BOOT_HDR_HI;
                end
                BOOT_HDR_HI: begin
                    if (frame_len == '0) begin
                        state_d = BOOT_RUN;
                    end else if (frame_len > MEMSIZE) begin
                        state_d = BOOT_HDR_LO;
                        err_d   = 1'b1;
                    end else begin
                        len_d   = frame_len[aw:0];
                        addr_d  = '0;
                        sum_d   = '0;
                        state_d = BOOT_DATA;
                    end
                end
                BOOT_DATA: begin
                    wen_d   = 1'b1;
                    waddr_d = addr_q[aw-1:0];
                    wdata_d = rx_data;
                    addr_d  = addr_inc;
                    sum_d   = sum_q + rx_data;
                    if (addr_inc == len_q) state_d = BOOT_CSUM;
                end
                BOOT_CSUM: begin
                    if (rx_data == sum_q) begin
                        state_d = BOOT_RUN;
                    end else begin
                        state_d = BOOT_HDR_LO;
                        err_d   = 1'b1;
                        addr_d  = '0;
                        sum_d   = '0;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    assign run          = (state_q == BOOT_RUN);
    assign core_rst_o   = !run;
    assign done_o       = run;
    assign err_o        = err_q;
    assign sram_addr_o  = run ? (core_wen_i ? core_waddr_i : core_raddr_i) : waddr_q;
    assign sram_wdata_o = run ? core_wdata_i : wdata_q;
    assign sram_wen_o   = run ? core_wen_i : wen_q;
    assign sram_ren_o   = run & core_ren_i;
    assign core_rdata_o = run ? sram_rdata_i : 8'h00;

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Loads a program image from a UART into the SoC SRAM before the core runs. It sits between the subservient SoC's SRAM port and `sram_rw`. While loading, it holds the core in reset and owns the SRAM write port. After a checksum-verified load it releases the core and passes the core's SRAM traffic straight through to the SRAM.

## Interface

Parameters:
- `aw`, 14, SRAM address width; `memsize = 1 << aw` bytes; `aw` ≤ 16.
- `CLKS_PER_BIT`, 104, clock cycles per UART bit; must be ≥ 4.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `uart_rx_i`  in  1  UART RX line, 8N1, idle high, asynchronous to `clk_i`.
- `core_rst_o`  out  1  reset to the SoC, active-high.
- `core_waddr_i`  in  aw  core write address.
- `core_wdata_i`  in  8  core write data.
- `core_wen_i`  in  1  core write enable.
- `core_raddr_i`  in  aw  core read address.
- `core_ren_i`  in  1  core read enable.
- `core_rdata_o`  out  8  read data returned to the core.
- `sram_addr_o`  out  aw  SRAM address.
- `sram_wdata_o`  out  8  SRAM write data.
- `sram_wen_o`  out  1  SRAM write enable.
- `sram_ren_o`  out  1  SRAM read enable.
- `sram_rdata_i`  in  8  SRAM read data.
- `done_o`  out  1  high while in RUN.
- `err_o`  out  1  sticky error flag; cleared only by reset.

## Operation

- **Frame format:** `len_lo`, `len_hi` (16-bit byte count N), then N payload bytes, then `csum` = sum of the payload mod 256.
- **FSM states:** HDR_LO → HDR_HI → DATA → CSUM → RUN.
- **HDR_HI → RUN, no writes:** when N = 0, boot from the existing SRAM contents.
- **HDR_HI → HDR_LO, `err_o` = 1:** when N > `memsize`.
- **DATA:** byte k (k = 0..N-1) is written to address k. The running sum is accumulated in an 8-bit wrapping register. The FSM moves to CSUM after byte N-1.
- **CSUM:** if the received byte equals the sum, go to RUN. Otherwise set `err_o` and go to HDR_LO; the address counter and sum are cleared.
- **Framing error:** a stop bit sampled low in any loading state drops the byte, sets `err_o` and returns to HDR_LO.
- **RUN:** terminal state. UART input is ignored. Pass-through is purely combinational:
  - `sram_addr_o` = `core_wen_i` ? `core_waddr_i` : `core_raddr_i`.
  - `sram_wdata_o`, `sram_wen_o`, `sram_ren_o` copy the core inputs.
  - `core_rdata_o` = `sram_rdata_i`.
- **Core inputs outside RUN:** ignored. `core_rdata_o` = 0.
- **UART receiver:**
  - 2-FF synchronizer on `uart_rx_i`.
  - A falling edge in idle starts reception. The start bit is re-checked at `CLKS_PER_BIT/2`; if it is high, the receiver returns to idle with no error.
  - Data bits are sampled at each bit middle, LSB first. The stop bit is sampled at its middle.
  - The receiver emits a one-cycle `valid` with the byte. No backpressure is needed, since one byte takes 10·`CLKS_PER_BIT` cycles.

## Timing

- **Reset values:** `core_rst_o` = 1, `done_o` = 0, `err_o` = 0, `sram_wen_o` = 0, `sram_ren_o` = 0, `sram_addr_o` = 0, `sram_wdata_o` = 0, `core_rdata_o` = 0. FSM in HDR_LO.
- **Byte valid:** asserted 1 cycle after the stop-bit mid-sample. Worst-case total latency from the RX falling edge is 2 (sync) + 9.5·`CLKS_PER_BIT` + 1 cycles.
- **Payload write:**
  - `sram_wen_o` is registered and high for exactly one cycle, the cycle after byte valid.
  - `sram_addr_o` = k and `sram_wdata_o` = byte during that cycle.
  - `sram_ren_o` stays 0 during loading.
- **Release:** `core_rst_o` falls and `done_o` rises together, 1 cycle after the valid of a matching `csum`, or of `len_hi` when N = 0.
- **Error flag:** `err_o` rises 1 cycle after the offending valid or stop sample.
- **Reset mid-operation:** all outputs return to reset values immediately (asynchronous). A full frame must then be resent; partially written SRAM contents are untrusted.
- **Address counter:** `aw`+1 bits wide so that N = `memsize` terminates without wrap.

## Structure

- Shared package `servisia_pkg` holds:
  - FSM state encodings for `uart_boot_loader`.
  - `UART_BITS` = 8.
- Sub-module `uart_rx` (params `CLKS_PER_BIT`) contains the synchronizer, bit timer and shift register. Outputs: `data_o[7:0]`, `valid_o`, `frame_err_o`.
- The top of this block holds the FSM, counter, checksum and SRAM mux.

## Test plan

1. **Reset:** assert `rst_i` mid-bit → all outputs at reset values within the same cycle; FSM in HDR_LO.
2. **Good load:** send 03 00 AA 55 01 00 →
   - SRAM writes (0,AA), (1,55), (2,01), one cycle each.
   - `core_rst_o` = 0 and `done_o` = 1 one cycle after the `csum` valid.
   - `err_o` = 0.
3. **Bad checksum, then recovery:** send 02 00 10 20 31 → `err_o` = 1, `core_rst_o` stays 1. Then send 01 00 7F 7F → RUN with `err_o` still 1.
4. **Framing error and glitch:**
   - Low stop bit during `len_hi` → `err_o` = 1, FSM returns to HDR_LO, no SRAM write.
   - A start-bit glitch shorter than `CLKS_PER_BIT/2` → no byte, no error.
5. **Length edge cases (`aw` = 14):**
   - N = 0 → RUN with no writes.
   - N = 0x4001 → `err_o` = 1, FSM in HDR_LO.
   - N = 0x4000 → last write to address 0x3FFF, then CSUM.
6. **RUN pass-through:**
   - `core_wen_i` = 1, `core_waddr_i` = 0x123, `core_raddr_i` = 0x456 → `sram_addr_o` = 0x123.
   - `core_wen_i` = 0 → `sram_addr_o` = 0x456 and `core_rdata_o` follows `sram_rdata_i`.
   - UART bytes in RUN → no effect.
